// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters,
// mispredict/redirect detection and running branch statistics.
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int ADDR_W   = 32,
    parameter int MODE     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              x_valid,
    input  logic [ADDR_W-1:0] x_pc,
    input  logic              x_is_branch,
    input  logic              x_taken,
    input  logic [ADDR_W-1:0] x_target,
    input  logic              x_pred_taken,
    input  logic [ADDR_W-1:0] x_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [ADDR_W-1:0]   r_target [ENTRIES];
    logic [31:0]         r_branches;
    logic [31:0]         r_mispredicts;
    logic [IDX_W-1:0]    w_f_idx;
    logic [IDX_W-1:0]    w_x_idx;
    logic                w_f_hit;
    logic                w_x_hit;
    logic                w_x_branch;
    logic                w_update;

    assign w_f_idx     = f_pc[IDX_W+1:2];
    assign w_x_idx     = x_pc[IDX_W+1:2];
    assign w_f_hit     = r_valid[w_f_idx] && r_tag[w_f_idx] == f_pc[ADDR_W-1:IDX_W+2];
    assign w_x_hit     = r_valid[w_x_idx] && r_tag[w_x_idx] == x_pc[ADDR_W-1:IDX_W+2];
    assign w_x_branch  = x_valid && x_is_branch;
    assign w_update    = MODE != 0 && w_x_branch;

    // Gated by reset so stale table contents never leak out during the reset cycle
    assign pred_taken  = MODE != 0 && !reset && f_valid && w_f_hit && r_ctr[w_f_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? r_target[w_f_idx] : f_pc + ADDR_W'(4);

    assign mispredict  = x_valid && (x_is_branch
                         ? (x_taken != x_pred_taken) || (x_taken && x_target != x_pred_target)
                         : x_pred_taken);
    assign redirect_pc = (x_is_branch && x_taken) ? x_target : x_pc + ADDR_W'(4);

    assign stat_branches    = r_branches;
    assign stat_mispredicts = r_mispredicts;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= CTR_WNT;
                r_target[i] <= '0;
            end
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else begin
            r_branches    <= r_branches + 32'(w_x_branch);
            r_mispredicts <= r_mispredicts + 32'(mispredict);
            if (w_update && w_x_hit) begin
                if (x_taken) begin
                    r_ctr[w_x_idx]    <= (r_ctr[w_x_idx] == CTR_MAX) ? CTR_MAX : r_ctr[w_x_idx] + CTR_BITS'(1);
                    r_target[w_x_idx] <= x_target;
                end else begin
                    r_ctr[w_x_idx]    <= (r_ctr[w_x_idx] == '0) ? '0 : r_ctr[w_x_idx] - CTR_BITS'(1);
                end
            end else if (w_update && x_taken) begin
                r_valid[w_x_idx]  <= 1'b1;
                r_tag[w_x_idx]    <= x_pc[ADDR_W-1:IDX_W+2];
                r_ctr[w_x_idx]    <= CTR_WT;
                r_target[w_x_idx] <= x_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor in dynamic and static modes.
module tb_branch_predictor;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic        x_valid = 1'b0;
    logic [31:0] x_pc = '0;
    logic        x_is_branch = 1'b0;
    logic        x_taken = 1'b0;
    logic [31:0] x_target = '0;
    logic        x_pred_taken = 1'b0;
    logic [31:0] x_pred_target = '0;
    logic        pred_taken, pred_taken0, mispredict, mispredict0;
    logic [31:0] pred_target, pred_target0, redirect_pc, redirect_pc0;
    logic [31:0] stat_branches, stat_branches0, stat_mispredicts, stat_mispredicts0;

    localparam logic [31:0] PC_A = 32'h0100_0010;
    localparam logic [31:0] PC_B = 32'h0100_0110;
    localparam logic [31:0] PC_C = 32'h0100_0020;
    localparam logic [31:0] PC_D = 32'h0100_0030;
    localparam logic [31:0] PC_E = 32'h0100_0040;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_br, exp_mp;
    logic [31:0] sb_q[$];
    bit hy_pred [11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit hy_tk   [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};

    always #5 clock = ~clock;

    branch_predictor #(.MODE(1)) dut (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .x_valid(x_valid), .x_pc(x_pc), .x_is_branch(x_is_branch), .x_taken(x_taken),
        .x_target(x_target), .x_pred_taken(x_pred_taken), .x_pred_target(x_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.MODE(0)) dut0 (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .pred_taken(pred_taken0), .pred_target(pred_target0),
        .x_valid(x_valid), .x_pc(x_pc), .x_is_branch(x_is_branch), .x_taken(x_taken),
        .x_target(x_target), .x_pred_taken(x_pred_taken), .x_pred_target(x_pred_target),
        .mispredict(mispredict0), .redirect_pc(redirect_pc0),
        .stat_branches(stat_branches0), .stat_mispredicts(stat_mispredicts0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = 'x;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        check(tag, got, e);
    endtask

    task automatic step();
        @(negedge clock);
        x_valid = 1'b0;
        x_is_branch = 1'b0;
        x_taken = 1'b0;
        x_pred_taken = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        f_valid = 1'b1;
        f_pc = pc;
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        x_valid = 1'b1;
        x_is_branch = br;
        x_taken = tk;
        x_pc = pc;
        x_target = tgt;
        x_pred_taken = ptk;
        x_pred_target = ptgt;
    endtask

    initial begin
        step();
        look(32'h0100_0000);
        expect_val(0);
        #1 compare("rst_pred_during", 32'(pred_taken));
        step();
        reset = 1'b0;
        step();
        look(32'h0100_0000);
        expect_val(0); expect_val(32'h0100_0004); expect_val(0); expect_val(0);
        #1;
        compare("rst_pred", 32'(pred_taken));
        compare("rst_target", pred_target);
        compare("rst_branches", stat_branches);
        compare("rst_mispredicts", stat_mispredicts);

        step();
        resolve(1, 1, PC_A, 32'h0100_0100, 0, PC_A + 4);
        expect_val(1); expect_val(32'h0100_0100);
        #1;
        compare("cold_mp", 32'(mispredict));
        compare("cold_redirect", redirect_pc);
        step();
        look(PC_A);
        expect_val(1); expect_val(32'h0100_0100); expect_val(1); expect_val(1);
        #1;
        compare("cold_pred", 32'(pred_taken));
        compare("cold_target", pred_target);
        compare("cold_branches", stat_branches);
        compare("cold_mispredicts", stat_mispredicts);
        exp_br = 1;
        exp_mp = 1;

        for (int i = 0; i < 11; i++) begin
            step();
            look(PC_A);
            resolve(1, hy_tk[i], PC_A, 32'h0100_0100, hy_pred[i], 32'h0100_0100);
            expect_val(32'(hy_pred[i]));
            expect_val(32'(hy_tk[i] != hy_pred[i]));
            exp_br++;
            if (hy_tk[i] != hy_pred[i]) exp_mp++;
            #1;
            compare($sformatf("hyst%0d_pred", i), 32'(pred_taken));
            compare($sformatf("hyst%0d_mp", i), 32'(mispredict));
        end
        step();
        look(PC_A);
        expect_val(0); expect_val(32'(exp_br)); expect_val(32'(exp_mp));
        #1;
        compare("hyst_final_pred", 32'(pred_taken));
        compare("hyst_branches", stat_branches);
        compare("hyst_mispredicts", stat_mispredicts);

        step();
        resolve(1, 1, PC_A, 32'h0100_0100, 0, PC_A + 4);
        step();
        look(PC_A);
        expect_val(1);
        #1 compare("alias_a_hit", 32'(pred_taken));
        step();
        look(PC_B);
        expect_val(0); expect_val(PC_B + 4);
        #1;
        compare("alias_b_miss", 32'(pred_taken));
        compare("alias_b_miss_tgt", pred_target);
        step();
        resolve(1, 1, PC_B, 32'h0100_0200, 0, PC_B + 4);
        expect_val(1); expect_val(32'h0100_0200);
        #1;
        compare("alias_b_mp", 32'(mispredict));
        compare("alias_b_redirect", redirect_pc);
        step();
        look(PC_B);
        expect_val(1); expect_val(32'h0100_0200);
        #1;
        compare("alias_b_hit", 32'(pred_taken));
        compare("alias_b_tgt", pred_target);
        step();
        look(PC_A);
        expect_val(0); expect_val(PC_A + 4);
        #1;
        compare("alias_a_evicted", 32'(pred_taken));
        compare("alias_a_tgt", pred_target);
        step();
        resolve(1, 1, PC_B, 32'h0100_0300, 1, 32'h0100_0200);
        expect_val(1); expect_val(32'h0100_0300);
        #1;
        compare("tgt_mp", 32'(mispredict));
        compare("tgt_redirect", redirect_pc);
        step();
        look(PC_B);
        expect_val(32'h0100_0300);
        #1 compare("tgt_updated", pred_target);
        step();
        resolve(0, 0, PC_B, 32'h0, 1, 32'h0100_0300);
        expect_val(1); expect_val(PC_B + 4);
        #1;
        compare("nonbr_mp", 32'(mispredict));
        compare("nonbr_redirect", redirect_pc);
        step();
        resolve(0, 0, PC_B, 32'h0, 0, PC_B + 4);
        expect_val(0);
        #1 compare("nonbr_ok", 32'(mispredict));

        step();
        look(PC_C);
        resolve(1, 1, PC_C, 32'h0100_0400, 0, PC_C + 4);
        expect_val(0); expect_val(PC_C + 4);
        #1;
        compare("rbw_same", 32'(pred_taken));
        compare("rbw_same_tgt", pred_target);
        step();
        look(PC_C);
        expect_val(1); expect_val(32'h0100_0400);
        #1;
        compare("rbw_next", 32'(pred_taken));
        compare("rbw_next_tgt", pred_target);

        step();
        look(32'hFFFF_FFFF);
        expect_val(32'h3);
        #1 compare("pc_wrap", pred_target);

        step();
        reset = 1'b1;
        look(PC_B);
        resolve(1, 1, PC_D, 32'h0100_0500, 0, PC_D + 4);
        expect_val(0);
        #1 compare("midrst_pred", 32'(pred_taken));
        step();
        reset = 1'b0;
        look(PC_D);
        expect_val(0); expect_val(0); expect_val(0);
        #1;
        compare("midrst_d_miss", 32'(pred_taken));
        compare("midrst_branches", stat_branches);
        compare("midrst_mispredicts", stat_mispredicts);
        step();
        look(PC_B);
        expect_val(0);
        #1 compare("midrst_b_cleared", 32'(pred_taken));

        for (int i = 0; i < 10; i++) begin
            step();
            look(PC_E);
            resolve(1, 1, PC_E, 32'h0100_0600, 0, PC_E + 4);
            expect_val(0);
            #1 compare($sformatf("static%0d_pred", i), 32'(pred_taken0));
        end
        step();
        look(PC_E);
        expect_val(0); expect_val(PC_E + 4); expect_val(10); expect_val(10); expect_val(1);
        #1;
        compare("static_pred", 32'(pred_taken0));
        compare("static_tgt", pred_target0);
        compare("static_branches", stat_branches0);
        compare("static_mispredicts", stat_mispredicts0);
        compare("dynamic_contrast", 32'(pred_taken));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
